// File: rtl/ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid
// Purpose  : Multi-lane EX/MEM pipeline register. It has a valid/ready
//            handshake, synchronous flush, a one-entry skid buffer and a
//            saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid #(
  parameter int LANES          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             ex_valid,
  output logic                             ex_ready,
  input  logic [LANES*REG_ADDR_WIDTH-1:0]  ex_wd,
  input  logic [LANES-1:0]                 ex_wreg,
  input  logic [LANES*DATA_WIDTH-1:0]      ex_wdata,
  input  logic [LANES-1:0]                 ex_inst_valid,
  input  logic [LANES*INST_WIDTH-1:0]      ex_inst,
  input  logic [LANES*ADDR_WIDTH-1:0]      ex_inst_pc,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic [LANES*REG_ADDR_WIDTH-1:0]  mem_wd,
  output logic [LANES-1:0]                 mem_wreg,
  output logic [LANES*DATA_WIDTH-1:0]      mem_wdata,
  output logic [LANES-1:0]                 mem_inst_valid,
  output logic [LANES*INST_WIDTH-1:0]      mem_inst,
  output logic [LANES*ADDR_WIDTH-1:0]      mem_inst_pc,
  output logic [31:0]                      stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept, drain;
  logic load_out_in, load_out_skid, load_skid_in;

  // Output register contents
  logic [LANES*REG_ADDR_WIDTH-1:0] out_wd;
  logic [LANES-1:0]                out_wreg;
  logic [LANES*DATA_WIDTH-1:0]     out_wdata;
  logic [LANES-1:0]                out_iv;
  logic [LANES*INST_WIDTH-1:0]     out_inst;
  logic [LANES*ADDR_WIDTH-1:0]     out_pc;

  // Skid register contents
  logic [LANES*REG_ADDR_WIDTH-1:0] skid_wd;
  logic [LANES-1:0]                skid_wreg;
  logic [LANES*DATA_WIDTH-1:0]     skid_wdata;
  logic [LANES-1:0]                skid_iv;
  logic [LANES*INST_WIDTH-1:0]     skid_inst;
  logic [LANES*ADDR_WIDTH-1:0]     skid_pc;

  logic [31:0] stall_cnt;

  // Handshake signals come only from registered state, so mem_ready never
  // reaches ex_ready combinationally.
  assign ex_ready  = (state != ST_FULL);
  assign mem_valid = (state != ST_EMPTY);
  assign accept    = ex_valid & ex_ready;
  assign drain     = mem_valid & mem_ready;

  // Next-state and load-select decode; flush drops everything in flight.
  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid_in  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_out_in = 1'b1;
          state_nxt   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (drain && accept) begin
          load_out_in = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end else if (accept) begin
          load_skid_in = 1'b1;
          state_nxt    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drain) begin
          load_out_skid = 1'b1;
          state_nxt     = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt     = ST_EMPTY;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid_in  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Output register: loads from EX or SKID; flush clears only the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wd    <= '0;
      out_wreg  <= '0;
      out_wdata <= '0;
      out_iv    <= '0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_wreg <= '0;
      out_iv   <= '0;
    end else if (load_out_in) begin
      out_wd    <= ex_wd;
      out_wreg  <= ex_wreg;
      out_wdata <= ex_wdata;
      out_iv    <= ex_inst_valid;
      out_inst  <= ex_inst;
      out_pc    <= ex_inst_pc;
    end else if (load_out_skid) begin
      out_wd    <= skid_wd;
      out_wreg  <= skid_wreg;
      out_wdata <= skid_wdata;
      out_iv    <= skid_iv;
      out_inst  <= skid_inst;
      out_pc    <= skid_pc;
    end
  end

  // Skid register: absorbs the one bundle accepted while MEM is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_wd    <= '0;
      skid_wreg  <= '0;
      skid_wdata <= '0;
      skid_iv    <= '0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      skid_wreg <= '0;
      skid_iv   <= '0;
    end else if (load_skid_in) begin
      skid_wd    <= ex_wd;
      skid_wreg  <= ex_wreg;
      skid_wdata <= ex_wdata;
      skid_iv    <= ex_inst_valid;
      skid_inst  <= ex_inst;
      skid_pc    <= ex_inst_pc;
    end
  end

  // Saturating stall counter; only rst clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (mem_valid && !mem_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign mem_wd         = out_wd;
  assign mem_wreg       = out_wreg & {LANES{mem_valid}};
  assign mem_wdata      = out_wdata;
  assign mem_inst_valid = out_iv & {LANES{mem_valid}};
  assign mem_inst       = out_inst;
  assign mem_inst_pc    = out_pc;
  assign stall_cycles   = stall_cnt;

endmodule
`default_nettype wire
